// File: rtl/shift_unit_pipe.sv
// Two-stage elastic barrel shifter (SLL/SRL/SRA/ROR) with tag sideband.
// Macro SHIFT_UNIT_ROTATE_EN enables ROR; otherwise op 11 retires as illegal with a zero result.
module shift_unit_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [1:0]                 i_op,
  input  logic [DATA_W-1:0]          i_a,
  input  logic [$clog2(DATA_W)-1:0]  i_shamt,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_W-1:0]          o_result,
  output logic [TAG_W-1:0]           o_tag,
  output logic                       o_illegal
);
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int LO_W    = (SHAMT_W + 1) / 2;
  localparam int HI_W    = SHAMT_W - LO_W;

  function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] d,
                                                input logic [1:0] op,
                                                input logic [SHAMT_W-1:0] amt);
    logic [DATA_W-1:0] r;
`ifdef SHIFT_UNIT_ROTATE_EN
    logic [2*DATA_W-1:0] w;
    w = {d, d} >> amt;
`endif
    r = '0;
    case (op)
      2'b00:   r = d << amt;
      2'b01:   r = d >> amt;
      2'b10:   r = $signed(d) >>> amt;
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11:   r = w[DATA_W-1:0];
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic [1:0]        r_s1_op;
  logic [HI_W-1:0]   r_s1_shamt_hi;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic [TAG_W-1:0]  r_s2_tag;
  logic              r_s2_illegal;

  logic              w_s2_free;
  logic [DATA_W-1:0] w_s1_next;
  logic [DATA_W-1:0] w_s2_next;
  logic              w_s1_illegal;

  // Stage 2 frees up when empty or retiring; stage 1 advances under the same condition.
  assign w_s2_free = !r_s2_valid || i_ready;
  assign o_ready   = i_flush || !r_s1_valid || w_s2_free;

  assign w_s1_next = f_shift(i_a, i_op, {{HI_W{1'b0}}, i_shamt[LO_W-1:0]});
  assign w_s2_next = f_shift(r_s1_data, r_s1_op, {r_s1_shamt_hi, {LO_W{1'b0}}});

`ifdef SHIFT_UNIT_ROTATE_EN
  assign w_s1_illegal = 1'b0;
`else
  assign w_s1_illegal = (r_s1_op == 2'b11);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_data     <= '0;
      r_s1_op       <= '0;
      r_s1_shamt_hi <= '0;
      r_s1_tag      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_data     <= '0;
      r_s2_tag      <= '0;
      r_s2_illegal  <= 1'b0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data    <= w_s2_next;
          r_s2_tag     <= r_s1_tag;
          r_s2_illegal <= w_s1_illegal;
        end
      end
      if (o_ready) begin
        r_s1_valid <= i_valid;
        if (i_valid) begin
          r_s1_data     <= w_s1_next;
          r_s1_op       <= i_op;
          r_s1_shamt_hi <= i_shamt[SHAMT_W-1:LO_W];
          r_s1_tag      <= i_tag;
        end
      end
    end
  end

  assign o_valid   = r_s2_valid;
  assign o_result  = r_s2_data;
  assign o_tag     = r_s2_tag;
  assign o_illegal = r_s2_illegal;
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed self-checking bench for shift_unit_pipe (DATA_W=32, TAG_W=5).
module tb_shift_unit_pipe;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid, o_illegal;
  logic [1:0]  i_op;
  logic [31:0] i_a, o_result;
  logic [4:0]  i_shamt, i_tag, o_tag;

  int errors = 0;
  int checks = 0;

  shift_unit_pipe #(.DATA_W(32), .TAG_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op), .i_a(i_a),
    .i_shamt(i_shamt), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_tag(o_tag), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] sh, input logic [4:0] tag);
    i_valid = v; i_op = op; i_a = a; i_shamt = sh; i_tag = tag;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    drive(1'b0, SLL, 32'h0, 5'd0, 5'd0);
    cyc(); cyc();
    i_rst_n = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", o_result); end
    checks++; if (o_tag !== 5'd0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", o_tag); end
    checks++; if (o_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", o_illegal); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_shift();
    logic [1:0]  ops [10];
    logic [31:0] as  [10];
    logic [4:0]  shs [10];
    logic [31:0] exps[10];
    ops[0] = SRA; as[0] = 32'h8000_0000; shs[0] = 5'd31; exps[0] = 32'hFFFF_FFFF;
    ops[1] = SRL; as[1] = 32'h8000_0000; shs[1] = 5'd31; exps[1] = 32'h0000_0001;
    ops[2] = SLL; as[2] = 32'h0000_0001; shs[2] = 5'd31; exps[2] = 32'h8000_0000;
    ops[3] = SLL; as[3] = 32'h1234_5678; shs[3] = 5'd5;  exps[3] = 32'h468A_CF00;
    ops[4] = SRA; as[4] = 32'hF000_0000; shs[4] = 5'd3;  exps[4] = 32'hFE00_0000;
    ops[5] = SRA; as[5] = 32'h7000_0000; shs[5] = 5'd4;  exps[5] = 32'h0700_0000;
    ops[6] = SRL; as[6] = 32'hFFFF_FFFF; shs[6] = 5'd17; exps[6] = 32'h0000_7FFF;
    ops[7] = SLL; as[7] = 32'hDEAD_BEEF; shs[7] = 5'd0;  exps[7] = 32'hDEAD_BEEF;
    ops[8] = SRL; as[8] = 32'hDEAD_BEEF; shs[8] = 5'd0;  exps[8] = 32'hDEAD_BEEF;
    ops[9] = SRA; as[9] = 32'h8000_0001; shs[9] = 5'd0;  exps[9] = 32'h8000_0001;
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, ops[k], as[k], shs[k], 5'(k + 1));
      cyc();
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL shift_lat1 vec=%0d got=%b exp=0", k, o_valid); end
      cyc();
      checks++;
      if (o_valid !== 1'b1 || o_result !== exps[k] || o_tag !== 5'(k + 1) || o_illegal !== 1'b0) begin
        errors++;
        $display("FAIL shift vec=%0d got v=%b r=%h t=%0d il=%b exp v=1 r=%h t=%0d il=0",
                 k, o_valid, o_result, o_tag, o_illegal, exps[k], k + 1);
      end
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exps[3];
    exps[0] = 32'h0F0F_0F0F; exps[1] = 32'h00F0_F0F0; exps[2] = 32'h000F_0F0F;
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, SRL, 32'hF0F0_F0F0, 5'(4 * (i + 1)), 5'(i + 1));
      else       i_valid = 1'b0;
      #1;
      if (i < 3) begin
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, o_ready); end
      end
      cyc();
      if (i >= 1 && i <= 3) begin
        checks++;
        if (o_valid !== 1'b1 || o_result !== exps[i-1] || o_tag !== 5'(i)) begin
          errors++;
          $display("FAIL b2b i=%0d got v=%b r=%h t=%0d exp v=1 r=%h t=%0d", i, o_valid, o_result, o_tag, exps[i-1], i);
        end
      end
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_stall();
    int nxt = 0;
    int got = 0;
    i_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(nxt < 5, SLL, 32'(nxt + 1), 5'd4, 5'(10 + nxt));
      #1;
      if (c >= 2) begin
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, o_ready); end
        checks++;
        if (o_valid !== 1'b1 || o_result !== 32'h10 || o_tag !== 5'd10) begin
          errors++; $display("FAIL stall_hold c=%0d got v=%b r=%h t=%0d exp v=1 r=10 t=10", c, o_valid, o_result, o_tag);
        end
      end
      if (i_valid && o_ready) nxt++;
      cyc();
    end
    checks++; if (nxt !== 2) begin errors++; $display("FAIL stall_accepted got=%0d exp=2", nxt); end
    i_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      drive(nxt < 5, SLL, 32'(nxt + 1), 5'd4, 5'(10 + nxt));
      #1;
      if (o_valid) begin
        checks++;
        if (o_result !== 32'((got + 1) << 4) || o_tag !== 5'(10 + got)) begin
          errors++; $display("FAIL stall_order n=%0d got r=%h t=%0d exp r=%h t=%0d",
                             got, o_result, o_tag, 32'((got + 1) << 4), 10 + got);
        end
        got++;
      end
      if (i_valid && o_ready) nxt++;
      cyc();
    end
    i_valid = 1'b0;
    checks++; if (got !== 5) begin errors++; $display("FAIL stall_retired got=%0d exp=5", got); end
    cyc();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_dup got=%b exp=0", o_valid); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    drive(1'b1, SLL, 32'h1, 5'd1, 5'd20); cyc();
    drive(1'b1, SLL, 32'h2, 5'd1, 5'd21); cyc();
    drive(1'b1, SLL, 32'h3, 5'd1, 5'd22);
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_preready got=%b exp=0", o_ready); end
    i_flush = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", o_ready); end
    cyc();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid0 got=%b exp=0", o_valid); end
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost c=%0d got=%b exp=0", c, o_valid); end
    end
    drive(1'b1, SRA, 32'h8000_0000, 5'd4, 5'd23); cyc();
    i_valid = 1'b0; cyc();
    checks++;
    if (o_valid !== 1'b1 || o_result !== 32'hF800_0000 || o_tag !== 5'd23) begin
      errors++; $display("FAIL flush_after got v=%b r=%h t=%0d exp v=1 r=f8000000 t=23", o_valid, o_result, o_tag);
    end
    cyc();
  endtask

  task automatic test_rotate();
    logic [31:0] as[2], exps[2];
    logic [4:0]  shs[2];
    logic        exp_il;
    as[0] = 32'h0000_0001; shs[0] = 5'd1;
    as[1] = 32'h0000_00F1; shs[1] = 5'd4;
`ifdef SHIFT_UNIT_ROTATE_EN
    exps[0] = 32'h8000_0000; exps[1] = 32'h1000_000F; exp_il = 1'b0;
`else
    exps[0] = 32'h0; exps[1] = 32'h0; exp_il = 1'b1;
`endif
    i_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, ROR, as[k], shs[k], 5'(7 + k)); cyc();
      i_valid = 1'b0; cyc();
      checks++;
      if (o_valid !== 1'b1 || o_result !== exps[k] || o_illegal !== exp_il || o_tag !== 5'(7 + k)) begin
        errors++; $display("FAIL ror k=%0d got v=%b r=%h il=%b t=%0d exp v=1 r=%h il=%b t=%0d",
                           k, o_valid, o_result, o_illegal, o_tag, exps[k], exp_il, 7 + k);
      end
    end
    cyc();
  endtask

  task automatic test_reset_midflight();
    i_ready = 1'b1;
    drive(1'b1, SRL, 32'hAAAA_0000, 5'd8, 5'd30); cyc();
    drive(1'b1, SRL, 32'h5555_0000, 5'd8, 5'd31); cyc();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", o_valid); end
    i_valid = 1'b0; i_rst_n = 1'b0; i_flush = 1'b1;
    cyc();
    i_rst_n = 1'b1; i_flush = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_result !== 32'h0 || o_tag !== 5'd0 || o_illegal !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid got v=%b r=%h t=%0d il=%b rdy=%b exp v=0 r=0 t=0 il=0 rdy=1",
                         o_valid, o_result, o_tag, o_illegal, o_ready);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost c=%0d got=%b exp=0", c, o_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_back_to_back();
    test_stall();
    test_flush();
    test_rotate();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
